// File: rtl/score_accumulator.sv
// rtl/score_accumulator.sv - four-player round scorer with saturating, frozen-at-end score buses
// Optional per-player press lockout is built when SCORE_LOCKOUT_EN is defined.
module score_accumulator #(
    parameter int W              = 7,
    parameter int MAX_SCORE      = 99,
    parameter int ROUND_CYCLES   = 1000,
    parameter int LOCKOUT_CYCLES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   btn,
    output logic [W-1:0] BusA,
    output logic [W-1:0] BusB,
    output logic [W-1:0] BusC,
    output logic [W-1:0] BusD,
    output logic         round_active,
    output logic         round_done,
    output logic         valid
);
    localparam int TW = $clog2(ROUND_CYCLES);

    if (MAX_SCORE > (2 ** W) - 1 || ROUND_CYCLES < 2 || LOCKOUT_CYCLES < 0) begin : gBadParams
        $error("score_accumulator: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, CLEAR, PLAY, DONE} stateT;

    stateT         state;
    stateT         nextState;
    logic [TW-1:0] timer;
    logic [3:0]    btnQ;
    logic [3:0]    press;
    logic [3:0]    counted;
    logic          lastTick;
    logic [W-1:0]  score [4];

    assign press    = btn & ~btnQ;
    assign lastTick = (timer == TW'(ROUND_CYCLES - 1));

`ifdef SCORE_LOCKOUT_EN
    localparam int LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
    logic [LW-1:0] lockCnt [4];

    always_comb begin
        counted = '0;
        for (int i = 0; i < 4; i++) begin
            counted[i] = press[i] && (state == PLAY) && (lockCnt[i] == '0);
        end
    end

    // A counted press re-arms the dead time; otherwise the counter drains to zero in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) lockCnt[i] <= '0;
        end else if (state == CLEAR) begin
            for (int i = 0; i < 4; i++) lockCnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (counted[i]) begin
                    lockCnt[i] <= LW'(LOCKOUT_CYCLES);
                end else if (lockCnt[i] != '0) begin
                    lockCnt[i] <= lockCnt[i] - LW'(1);
                end
            end
        end
    end
`else
    assign counted = press & {4{state == PLAY}};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = CLEAR;
            CLEAR:   nextState = PLAY;
            PLAY:    if (lastTick) nextState = DONE;
            DONE:    if (start) nextState = CLEAR;
            default: nextState = IDLE;
        endcase
    end

    // btnQ tracks btn in every state so a button held across CLEAR never looks like a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btnQ       <= '0;
            timer      <= '0;
            round_done <= 1'b0;
        end else begin
            btnQ       <= btn;
            round_done <= (state == PLAY) && lastTick;
            if (state == CLEAR) begin
                timer <= '0;
            end else if (state == PLAY && !lastTick) begin
                timer <= timer + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) score[i] <= '0;
        end else if (state == CLEAR) begin
            for (int i = 0; i < 4; i++) score[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (counted[i] && score[i] < W'(MAX_SCORE)) begin
                    score[i] <= score[i] + W'(1);
                end
            end
        end
    end

    assign BusA         = score[0];
    assign BusB         = score[1];
    assign BusC         = score[2];
    assign BusD         = score[3];
    assign round_active = (state == PLAY);
    assign valid        = (state == DONE);
endmodule

// File: tb/tb_score_accumulator.sv
// tb/tb_score_accumulator.sv - scoreboard bench for score_accumulator (default and SCORE_LOCKOUT_EN builds)
module tb_score_accumulator;
    localparam int W  = 7;
    localparam int R  = 240;
    localparam int LC = 8;
`ifdef SCORE_LOCKOUT_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   btn;
    logic [W-1:0] BusA, BusB, BusC, BusD;
    logic         round_active, round_done, valid;

    int checks   = 0;
    int failures = 0;

    logic [4*W-1:0] sbQ [$];

    score_accumulator #(.W(W), .MAX_SCORE(99), .ROUND_CYCLES(R), .LOCKOUT_CYCLES(LC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .btn(btn),
        .BusA(BusA), .BusB(BusB), .BusC(BusC), .BusD(BusD),
        .round_active(round_active), .round_done(round_done), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkBuses(input string name, input int a, input int b, input int c, input int d);
        check({name, "_A"}, 32'(BusA), a);
        check({name, "_B"}, 32'(BusB), b);
        check({name, "_C"}, 32'(BusC), c);
        check({name, "_D"}, 32'(BusD), d);
    endtask

    task automatic pushExp(input int a, input int b, input int c, input int d);
        sbQ.push_back({W'(a), W'(b), W'(c), W'(d)});
    endtask

    // Called at a negedge; returns at the negedge just before the first PLAY edge (timer = 0).
    task automatic startRound();
        start = 1'b1;
        @(negedge clk);
        check("clear_not_active", 32'(round_active), 0);
        start = 1'b0;
        @(negedge clk);
        check("play_active", 32'(round_active), 1);
        checkBuses("clear_zero", 0, 0, 0, 0);
    endtask

    // Monitor: pops the expected final scores on round_done, then holds them for every DONE cycle.
    logic [W-1:0] expA, expB, expC, expD;
    bit have = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (round_done) begin
                check("done_valid", 32'(valid), 1);
                checks++;
                if (sbQ.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_done: got round_done with empty scoreboard expected none");
                end else begin
                    {expA, expB, expC, expD} = sbQ.pop_front();
                    have = 1'b1;
                    checkBuses("round", expA, expB, expC, expD);
                end
            end else if (valid && have) begin
                checkBuses("frozen", expA, expB, expC, expD);
            end else if (!have) begin
                check("valid_without_done", 32'(valid), 0);
            end
            if (!valid) have = 1'b0;
        end else begin
            have = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        btn   = 4'b0;
        repeat (2) @(negedge clk);
        checkBuses("reset", 0, 0, 0, 0);
        check("reset_active", 32'(round_active), 0);
        check("reset_done", 32'(round_done), 0);
        check("reset_valid", 32'(valid), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_active", 32'(round_active), 0);

        // Round 1: spaced pulses, simultaneous press, press on final PLAY cycle, presses in DONE.
        pushExp(LOCK ? 2 : 4, 1, LOCK ? 2 : 6, 2);
        startRound();
        for (int k = 0; k < R; k++) begin
            btn = 4'b0;
            if (k <= 4 && k % 2 == 0) btn[0] = 1'b1;
            if (k <= 8 && k % 2 == 0) btn[2] = 1'b1;
            if (k == 20) btn = 4'b1111;
            if (k == R - 1) btn[3] = 1'b1;
            @(negedge clk);
            if (k == 20) checkBuses("all_press", LOCK ? 2 : 4, 1, LOCK ? 2 : 6, 1);
        end
        btn = 4'b0;
        @(negedge clk);
        btn = 4'b1111;
        @(negedge clk);
        btn = 4'b0;
        @(negedge clk);

        // Round 2: D held across start, then re-pressed; B mashed into saturation.
        btn = 4'b1000;
        @(negedge clk);
        pushExp(0, LOCK ? 23 : 99, 0, 1);
        startRound();
        for (int k = 0; k < R; k++) begin
            btn = 4'b0;
            if (k < 5 || k == 7) btn[3] = 1'b1;
            if (k >= 10 && k % 2 == 0) btn[1] = 1'b1;
            @(negedge clk);
            if (k == 6) check("held_D", 32'(BusD), 0);
            if (k == 8) check("repress_D", 32'(BusD), 1);
            if (k == 206) check("sat_reach_B", 32'(BusB), LOCK ? 20 : 99);
            if (k == 208) check("sat_hold_B", 32'(BusB), LOCK ? 20 : 99);
        end
        btn = 4'b0;
        @(negedge clk);

        // Round 3: A pressed every 2 cycles for 32 cycles.
        pushExp(LOCK ? 4 : 16, 0, 0, 0);
        startRound();
        for (int k = 0; k < R; k++) begin
            btn = (k < 32 && k % 2 == 0) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (k == 31) check("mash_A", 32'(BusA), LOCK ? 4 : 16);
        end
        btn = 4'b0;
        @(negedge clk);

        // Round 4: asynchronous reset mid-PLAY; no result may be flagged.
        startRound();
        for (int k = 0; k < 50; k++) begin
            btn = (k == 3) ? 4'b0100 : 4'b0000;
            @(negedge clk);
        end
        check("pre_reset_C", 32'(BusC), 1);
        #2 rst_n = 1'b0;
        #1;
        checkBuses("async_reset", 0, 0, 0, 0);
        check("async_reset_active", 32'(round_active), 0);
        check("async_reset_done", 32'(round_done), 0);
        check("async_reset_valid", 32'(valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", 32'(round_active), 0);
        check("post_reset_valid", 32'(valid), 0);

        // Round 5: clean round after reset with no presses.
        pushExp(0, 0, 0, 0);
        startRound();
        for (int k = 0; k < R; k++) @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sbQ.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
